// File: rtl/pick_arbiter.sv
// pick_arbiter
// Two-way arbiter that hands the keyboard direction stream to either the
// LR pick or the UD pick. A grant is held for a minimum number of frames,
// is cut short by a timeout or by the LR pick reaching its stop column,
// and every grant is followed by a fixed cool-down before the next one.
// Simultaneous requests alternate between the two sides.
module pick_arbiter #(
    parameter int unsigned HOLD_FRAMES    = 30,
    parameter int unsigned TIMEOUT_FRAMES = 255,
    parameter int unsigned COOL_FRAMES    = 4,
    parameter int unsigned LR_STOP_X      = 488
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       reqLR,
    input  logic       reqUD,
    input  logic [2:0] keyDir,
    input  logic [9:0] pickLRx,
    output logic       pickModeLR,
    output logic       pickModeUD,
    output logic [2:0] LRdir,
    output logic [2:0] UDdir,
    output logic [1:0] owner,
    output logic [7:0] turnCount
);

    // The encoding doubles as the owner output value.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_LR = 2'd1,
        ST_GRANT_UD = 2'd2,
        ST_COOL     = 2'd3
    } state_t;

    // Only the three "safe" direction codes are forwarded to a pick; any
    // other code from the keyboard decoder is treated as "no direction".
    function automatic logic [2:0] filter_dir(input logic [2:0] code);
        logic [2:0] result;
        case (code)
            3'b000:  result = 3'b000;
            3'b001:  result = 3'b001;
            3'b010:  result = 3'b010;
            default: result = 3'b000;
        endcase
        return result;
    endfunction

    // Frame counter increment that sticks at its maximum value.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    // State and registered outputs
    state_t     state_r;
    logic [7:0] cnt_r;          // frames spent in the current grant / cool phase
    logic [7:0] turn_cnt_r;     // grants issued since reset, wraps
    logic       last_lr_r;      // 1: most recent grant went to LR, 0: to UD
    logic       pick_lr_r;
    logic       pick_ud_r;
    logic [2:0] lr_dir_r;
    logic [2:0] ud_dir_r;

    // Decision signals
    logic       grant_lr_s;
    logic       grant_ud_s;
    logic       hold_done_s;
    logic       timeout_s;
    logic       lr_stop_s;
    logic       cool_done_s;
    logic       lr_exit_s;
    logic       ud_exit_s;
    logic [2:0] key_dir_s;
    logic [7:0] cnt_inc_s;

    // Pick the side to grant from IDLE; ties go to the side not served last.
    always_comb begin
        grant_lr_s = 1'b0;
        grant_ud_s = 1'b0;
        if (reqLR && reqUD) begin
            if (last_lr_r) begin
                grant_ud_s = 1'b1;
            end else begin
                grant_lr_s = 1'b1;
            end
        end else if (reqLR) begin
            grant_lr_s = 1'b1;
        end else if (reqUD) begin
            grant_ud_s = 1'b1;
        end else begin
            grant_lr_s = 1'b0;
            grant_ud_s = 1'b0;
        end
    end

    // Grant-exit and cool-done conditions, evaluated on the current counter.
    // Comparisons are done in 32 bits so small parameter values cannot wrap.
    always_comb begin
        hold_done_s = (({24'd0, cnt_r} + 32'd1) >= HOLD_FRAMES);
        timeout_s   = (({24'd0, cnt_r} + 32'd1) == TIMEOUT_FRAMES);
        lr_stop_s   = ({22'd0, pickLRx} <= LR_STOP_X);
        cool_done_s = (({24'd0, cnt_r} + 32'd1) >= COOL_FRAMES);
        // Stop/timeout and the hold check all lead to the same single move
        // into COOL, so they are simply OR-ed together.
        lr_exit_s   = timeout_s || lr_stop_s || (hold_done_s && !reqLR);
        ud_exit_s   = timeout_s || (hold_done_s && !reqUD);
        key_dir_s   = filter_dir(keyDir);
        cnt_inc_s   = sat_inc(cnt_r);
    end

    // Arbiter FSM with all outputs registered alongside the state.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            turn_cnt_r <= 8'd0;
            last_lr_r  <= 1'b0;
            pick_lr_r  <= 1'b0;
            pick_ud_r  <= 1'b0;
            lr_dir_r   <= 3'b000;
            ud_dir_r   <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_lr_s) begin
                        state_r    <= ST_GRANT_LR;
                        cnt_r      <= 8'd0;
                        turn_cnt_r <= turn_cnt_r + 8'd1;
                        last_lr_r  <= 1'b1;
                        pick_lr_r  <= 1'b1;
                        pick_ud_r  <= 1'b0;
                        lr_dir_r   <= key_dir_s;
                        ud_dir_r   <= 3'b000;
                    end else if (grant_ud_s) begin
                        state_r    <= ST_GRANT_UD;
                        cnt_r      <= 8'd0;
                        turn_cnt_r <= turn_cnt_r + 8'd1;
                        last_lr_r  <= 1'b0;
                        pick_lr_r  <= 1'b0;
                        pick_ud_r  <= 1'b1;
                        lr_dir_r   <= 3'b000;
                        ud_dir_r   <= key_dir_s;
                    end else begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= 8'd0;
                        pick_lr_r  <= 1'b0;
                        pick_ud_r  <= 1'b0;
                        lr_dir_r   <= 3'b000;
                        ud_dir_r   <= 3'b000;
                    end
                end

                ST_GRANT_LR: begin
                    if (lr_exit_s) begin
                        state_r   <= ST_COOL;
                        cnt_r     <= 8'd0;
                        pick_lr_r <= 1'b0;
                        pick_ud_r <= 1'b0;
                        lr_dir_r  <= 3'b000;
                        ud_dir_r  <= 3'b000;
                    end else begin
                        state_r   <= ST_GRANT_LR;
                        cnt_r     <= cnt_inc_s;
                        pick_lr_r <= 1'b1;
                        pick_ud_r <= 1'b0;
                        lr_dir_r  <= key_dir_s;
                        ud_dir_r  <= 3'b000;
                    end
                end

                ST_GRANT_UD: begin
                    if (ud_exit_s) begin
                        state_r   <= ST_COOL;
                        cnt_r     <= 8'd0;
                        pick_lr_r <= 1'b0;
                        pick_ud_r <= 1'b0;
                        lr_dir_r  <= 3'b000;
                        ud_dir_r  <= 3'b000;
                    end else begin
                        state_r   <= ST_GRANT_UD;
                        cnt_r     <= cnt_inc_s;
                        pick_lr_r <= 1'b0;
                        pick_ud_r <= 1'b1;
                        lr_dir_r  <= 3'b000;
                        ud_dir_r  <= key_dir_s;
                    end
                end

                ST_COOL: begin
                    // Requests are ignored here; the counter alone decides.
                    if (cool_done_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 8'd0;
                    end else begin
                        state_r <= ST_COOL;
                        cnt_r   <= cnt_inc_s;
                    end
                    pick_lr_r <= 1'b0;
                    pick_ud_r <= 1'b0;
                    lr_dir_r  <= 3'b000;
                    ud_dir_r  <= 3'b000;
                end

                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 8'd0;
                    pick_lr_r <= 1'b0;
                    pick_ud_r <= 1'b0;
                    lr_dir_r  <= 3'b000;
                    ud_dir_r  <= 3'b000;
                end
            endcase
        end
    end

    assign owner      = state_r;
    assign pickModeLR = pick_lr_r;
    assign pickModeUD = pick_ud_r;
    assign LRdir      = lr_dir_r;
    assign UDdir      = ud_dir_r;
    assign turnCount  = turn_cnt_r;

endmodule

// File: tb/tb_pick_arbiter.sv
// Testbench for pick_arbiter: directed scenarios with literal expectations
// followed by randomized requests, all checked every frame against a
// behavioural model of the arbitration rules.
module tb_pick_arbiter;

    localparam int HOLD    = 30;
    localparam int TIMEOUT = 255;
    localparam int COOL    = 4;
    localparam int LR_STOP = 488;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic       reqLR     = 1'b0;
    logic       reqUD     = 1'b0;
    logic [2:0] keyDir    = 3'b000;
    logic [9:0] pickLRx   = 10'd600;
    logic       pickModeLR;
    logic       pickModeUD;
    logic [2:0] LRdir;
    logic [2:0] UDdir;
    logic [1:0] owner;
    logic [7:0] turnCount;

    pick_arbiter #(
        .HOLD_FRAMES   (HOLD),
        .TIMEOUT_FRAMES(TIMEOUT),
        .COOL_FRAMES   (COOL),
        .LR_STOP_X     (LR_STOP)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .reqLR     (reqLR),
        .reqUD     (reqUD),
        .keyDir    (keyDir),
        .pickLRx   (pickLRx),
        .pickModeLR(pickModeLR),
        .pickModeUD(pickModeUD),
        .LRdir     (LRdir),
        .UDdir     (UDdir),
        .owner     (owner),
        .turnCount (turnCount)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 LR granted, 2 UD granted, 3 cooling down
    int         m_phase;
    int         m_age;        // frames already spent in the current grant
    int         m_cool_left;  // cool-down frames still to go
    int         m_turns;      // grants modulo 256
    int         m_grants;     // grants, never wraps
    bit         m_last_lr;
    logic [2:0] m_lrdir;
    logic [2:0] m_uddir;

    function automatic logic [2:0] safe_dir(input logic [2:0] kd);
        return (kd <= 3'd2) ? kd : 3'd0;
    endfunction

    task automatic model_reset();
        m_phase     = 0;
        m_age       = 0;
        m_cool_left = 0;
        m_turns     = 0;
        m_last_lr   = 1'b0;
        m_lrdir     = 3'd0;
        m_uddir     = 3'd0;
    endtask

    task automatic model_step();
        int  side;
        bit  my_req;
        bit  stop;
        if (!Reset) begin
            model_reset();
        end else begin
            if (m_phase == 0) begin
                side = 0;
                if (reqLR && reqUD) side = m_last_lr ? 2 : 1;
                else if (reqLR)     side = 1;
                else if (reqUD)     side = 2;
                if (side != 0) begin
                    m_phase   = side;
                    m_age     = 0;
                    m_turns   = (m_turns + 1) % 256;
                    m_grants  = m_grants + 1;
                    m_last_lr = (side == 1);
                end
            end else if (m_phase == 1 || m_phase == 2) begin
                my_req = (m_phase == 1) ? reqLR : reqUD;
                stop   = (m_age == TIMEOUT - 1) || (m_age >= HOLD - 1 && !my_req) ||
                         (m_phase == 1 && int'(pickLRx) <= LR_STOP);
                if (stop) begin
                    m_phase     = 3;
                    m_cool_left = COOL;
                end else begin
                    m_age = (m_age < 255) ? m_age + 1 : 255;
                end
            end else begin
                m_cool_left = m_cool_left - 1;
                if (m_cool_left == 0) m_phase = 0;
            end
            m_lrdir = (m_phase == 1) ? safe_dir(keyDir) : 3'd0;
            m_uddir = (m_phase == 2) ? safe_dir(keyDir) : 3'd0;
        end
    endtask

    bit chk_en   = 1'b0;
    bit saw_wrap = 1'b0;
    int prev_turn = 0;

    // Per-frame comparison of every output against the model.
    always @(posedge frame_clk) begin
        if (chk_en) begin
            model_step();
            #1;
            check("owner",      int'(owner),      m_phase);
            check("pickModeLR", int'(pickModeLR), int'(m_phase == 1));
            check("pickModeUD", int'(pickModeUD), int'(m_phase == 2));
            check("LRdir",      int'(LRdir),      int'(m_lrdir));
            check("UDdir",      int'(UDdir),      int'(m_uddir));
            check("turnCount",  int'(turnCount),  m_turns);
            check("mutex",      int'(pickModeLR & pickModeUD), 0);
            if (prev_turn == 255 && turnCount == 8'd0) saw_wrap = 1'b1;
            prev_turn = int'(turnCount);
        end
    end

    task automatic wait_owner(input int target, input int budget, input string name);
        int n = 0;
        while (int'(owner) != target && n < budget) begin
            @(negedge frame_clk);
            n++;
        end
        check(name, int'(owner), target);
    endtask

    initial begin
        int n;
        int g0;
        int cyc;
        int r;
        m_grants = 0;
        model_reset();

        // Asynchronous reset: outputs clear without any clock edge.
        #2 Reset = 1'b0;
        #1;
        check("rst owner",     int'(owner), 0);
        check("rst pickLR",    int'(pickModeLR), 0);
        check("rst pickUD",    int'(pickModeUD), 0);
        check("rst turnCount", int'(turnCount), 0);
        chk_en = 1'b1;
        @(negedge frame_clk);
        @(negedge frame_clk);

        // Simultaneous first request goes to LR after one edge.
        Reset   = 1'b1;
        reqLR   = 1'b1;
        reqUD   = 1'b1;
        keyDir  = 3'b010;
        pickLRx = 10'd600;
        @(negedge frame_clk);
        check("first owner",     int'(owner), 1);
        check("first pickLR",    int'(pickModeLR), 1);
        check("first turnCount", int'(turnCount), 1);
        check("first LRdir",     int'(LRdir), 2);
        check("first UDdir",     int'(UDdir), 0);

        // Held request: grant runs to the timeout, then 4 cool frames, then UD.
        n = 0;
        while (owner == 2'd1 && n < 400) begin
            n++;
            @(negedge frame_clk);
        end
        check("timeout grant frames", n, 255);
        check("timeout to cool", int'(owner), 3);
        n = 0;
        while (owner == 2'd3 && n < 20) begin
            n++;
            @(negedge frame_clk);
        end
        check("cool frames", n, 4);
        check("idle after cool", int'(owner), 0);
        @(negedge frame_clk);
        check("round robin owner", int'(owner), 2);
        check("round robin turns", int'(turnCount), 2);

        // Release UD so its grant ends at the hold limit; LR follows.
        reqUD = 1'b0;
        wait_owner(1, 100, "lr regrant");

        // Request dropped at frame 5 is still held to counter 29.
        n = 0;
        while (owner == 2'd1 && n < 400) begin
            if (n == 5) reqLR = 1'b0;
            n++;
            @(negedge frame_clk);
        end
        check("hold grant frames", n, 30);
        check("hold to cool", int'(owner), 3);

        // LR reaching the stop column ends the grant on the next edge.
        reqLR = 1'b1;
        wait_owner(1, 50, "lr grant for stop");
        n = 0;
        while (owner == 2'd1 && n < 400) begin
            if (n == 10) pickLRx = 10'd488;
            n++;
            @(negedge frame_clk);
        end
        check("stop grant frames", n, 11);
        check("stop owner", int'(owner), 3);
        check("stop pickLR", int'(pickModeLR), 0);

        // UD grant with an illegal direction code, then reset mid-grant.
        reqLR   = 1'b0;
        reqUD   = 1'b1;
        keyDir  = 3'b111;
        pickLRx = 10'd600;
        wait_owner(2, 50, "ud grant");
        check("bad dir UDdir", int'(UDdir), 0);
        check("bad dir pickUD", int'(pickModeUD), 1);
        @(negedge frame_clk);
        @(negedge frame_clk);
        #2 Reset = 1'b0;
        #1;
        check("midrst owner",  int'(owner), 0);
        check("midrst pickUD", int'(pickModeUD), 0);
        check("midrst UDdir",  int'(UDdir), 0);
        check("midrst turns",  int'(turnCount), 0);
        model_reset();
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b1;
        @(negedge frame_clk);
        check("post rst owner", int'(owner), 2);
        check("post rst turns", int'(turnCount), 1);

        // Randomized requests until 300 grants have been issued.
        g0  = m_grants;
        cyc = 0;
        while ((m_grants - g0) < 300 && cyc < 60000) begin
            @(negedge frame_clk);
            if ($urandom_range(0, 7) == 0) reqLR = ~reqLR;
            if ($urandom_range(0, 7) == 0) reqUD = ~reqUD;
            keyDir = 3'($urandom_range(0, 7));
            r = int'($urandom_range(0, 15));
            if (r == 0)      pickLRx = 10'd488;
            else if (r == 1) pickLRx = 10'd489;
            else if (r < 5)  pickLRx = 10'($urandom_range(0, 487));
            else             pickLRx = 10'($urandom_range(490, 1023));
            cyc++;
        end
        check("random grants reached", int'((m_grants - g0) >= 300), 1);
        check("turnCount wrapped", int'(saw_wrap), 1);

        reqLR = 1'b0;
        reqUD = 1'b0;
        repeat (5) @(negedge frame_clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pick_arbiter.md
PICK_ARBITER -- requirements
Module: pick_arbiter

Interface
REQ-001 Parameter HOLD_FRAMES, default 30, minimum frames a grant is held before a released request ends it.
REQ-002 Parameter TIMEOUT_FRAMES, default 255, maximum frames in any grant (range 2..255).
REQ-003 Parameter COOL_FRAMES, default 4, frames spent in COOL between grants (range 1..255).
REQ-004 Parameter LR_STOP_X, default 488, LR pick x-coordinate that ends an LR grant.
REQ-005 frame_clk  in  1  frame clock; all state changes on its rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 reqLR  in  1  level request for the LR pick.
REQ-008 reqUD  in  1  level request for the UD pick.
REQ-009 keyDir  in  3  raw direction code from the keyboard decoder.
REQ-010 pickLRx  in  10  current LR pick x position.
REQ-011 pickModeLR  out  1  enables the LR pick.
REQ-012 pickModeUD  out  1  enables the UD pick.
REQ-013 LRdir  out  3  direction code driven to the LR pick.
REQ-014 UDdir  out  3  direction code driven to the UD pick.
REQ-015 owner  out  2  current state: 0 IDLE, 1 GRANT_LR, 2 GRANT_UD, 3 COOL.
REQ-016 turnCount  out  8  number of grants issued since reset.

Function
REQ-017 The block SHALL implement exactly four states (IDLE, GRANT_LR, GRANT_UD, COOL), with all outputs registered and owner driven directly from the state register.
REQ-018 IDLE: reqLR only -> GRANT_LR; reqUD only -> GRANT_UD; both -> the side not recorded in lastOwner; neither -> stay in IDLE.
REQ-019 lastOwner SHALL update on each grant entry and SHALL reset to UD, so the first simultaneous request goes to LR.
REQ-020 A grant SHALL become visible on the first frame_clk edge at which the request is sampled in IDLE, i.e. one-edge latency.
REQ-021 On grant entry, the 8-bit frame counter SHALL clear to 0 and turnCount SHALL increment, wrapping 255 -> 0.
REQ-022 In GRANT_x, the counter SHALL increment by 1 each frame and SHALL saturate at 255.
REQ-023 In GRANT_x, pickMode_x SHALL be 1 and the other pickMode SHALL be 0.
REQ-024 In GRANT_x, x_dir SHALL equal keyDir when keyDir is in {000, 001, 010}, else 000; the other dir output SHALL be 000.
REQ-025 GRANT_x SHALL exit to COOL when any of the following holds:
- counter >= HOLD_FRAMES-1 and req_x = 0;
- counter = TIMEOUT_FRAMES-1;
- GRANT_LR only: pickLRx <= LR_STOP_X.
REQ-026 Releasing the request before HOLD_FRAMES SHALL NOT end the grant; the grant holds until HOLD_FRAMES or a stop condition.
REQ-027 COOL: both pickMode outputs SHALL be 0 and both dir outputs 000; the state SHALL last exactly COOL_FRAMES frames and then go to IDLE, ignoring requests.
REQ-028 In IDLE, both pickMode outputs SHALL be 0 and both dir outputs 000.
REQ-029 pickModeLR and pickModeUD SHALL never both be 1 in any cycle.
REQ-030 The stop condition SHALL take priority over a same-cycle HOLD check; when multiple exit conditions coincide, the result is a single transition to COOL.

Reset
REQ-031 While Reset = 0, without waiting for a clock edge: state = IDLE, owner = 0, both pickMode = 0, both dir = 000, counter = 0, turnCount = 0, lastOwner = UD.
REQ-032 Reset asserted during a grant SHALL drop pickMode to 0 immediately; the first grant after release SHALL follow REQ-018 using the reset lastOwner.

Verification
REQ-033 Reset low, then high; reqLR = reqUD = 1 at the same edge -> owner = 1 and pickModeLR = 1 after one edge; turnCount = 1.
REQ-034 GRANT_LR with keyDir = 010, reqLR held, pickLRx = 600 -> LRdir = 010 and UDdir = 000; owner = 3 at counter 254; after 4 COOL frames the grant goes to UD (round-robin), turnCount = 2.
REQ-035 GRANT_LR with reqLR dropped at frame 5 -> the grant is held until counter = 29; then COOL.
REQ-036 GRANT_LR with pickLRx driven to 488 at frame 10 -> owner = 3 on the next edge; pickModeLR = 0.
REQ-037 GRANT_UD with keyDir = 111 -> UDdir = 000; Reset pulsed low mid-grant -> all outputs zero asynchronously; after release, a reqUD-only request gives owner = 2 with turnCount = 1.
REQ-038 Across 300 random requests, pickModeLR & pickModeUD SHALL never both be 1, and turnCount SHALL wrap from 255 to 0.
